conv1x1_ofm_writer: RTL and testbench
=====================================

Name: conv1x1_ofm_writer

Overview:
Sits at the output end of the 1x1 convolution PE array. Each PE group completes a 4-filter result for one pixel and raises the finish strobe. This block captures the four partial sums on that strobe and buffers the groups in a small FIFO. It then serialises them into word writes to OFM memory, generating addresses in pixel-major order (addr = pixel*num_filter + filter), and reports completion of the layer.

Parameters:
DATA_W, 32, width of one PE accumulator result and one OFM write word
NUM_PE, 4, PEs per group; fixed at 4, filters produced per capture
FIFO_DEPTH, 8, number of 4-word groups buffered; power of two
ADDR_W, 32, OFM word address width

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; latches config, begins a layer
cfg_num_filter  input  11  filters per pixel; bits [1:0] ignored (rounded down to a multiple of 4)
cfg_num_pixel  input  16  pixels in the layer
pe_finish  input  4  per-PE finish strobes (level, may stay high several cycles)
pe_psum  input  NUM_PE*DATA_W  PE results; PE0 in the LSBs
wr_valid  output  1  write request valid
wr_ready  input  1  memory accepts the write this cycle
wr_addr  output  ADDR_W  OFM word address
wr_data  output  DATA_W  OFM word
busy  output  1  high from start until done
done  output  1  one-cycle pulse when the last word is accepted
overflow  output  1  sticky; a capture was dropped; cleared by start

Behaviour:
- Reset: all outputs 0. FIFO is emptied, all counters are 0, state is IDLE.
- States:
  - IDLE: on start, latch nf = cfg_num_filter & ~3 and np = cfg_num_pixel, clear counters and overflow, then go to RUN. If nf == 0 or np == 0, go to DONE instead.
  - RUN: capture and drain run concurrently. When the write count equals np*nf words, go to DONE.
  - DONE: done = 1 for one cycle, busy = 0, then return to IDLE.
- busy is 1 in RUN; 0 in IDLE and DONE. start is ignored outside IDLE.
- Capture:
  - Edge-detect on (pe_finish == 4'b1111): a capture fires in the first cycle all four bits are high, after a cycle where they were not all high.
  - A capture pushes pe_psum as one group.
  - Captures in IDLE or DONE are ignored.
- Full FIFO:
  - If a capture fires while the FIFO is full, the group is dropped and overflow is set.
  - Exception: if the head group's 4th word handshakes in the same cycle, the slot frees and the capture is accepted.
- Excess captures: once np*nf/4 groups have been accepted, further captures are dropped and set overflow.
- Drain:
  - The head group is emitted as 4 beats, PE0 first.
  - wr_valid is high whenever the FIFO is non-empty in RUN.
  - A beat completes on wr_valid && wr_ready.
  - wr_addr and wr_data hold stable while wr_valid && !wr_ready.
  - The group pops on its 4th handshake.
- Latency: a capture in cycle N into an empty FIFO gives wr_valid = 1 in cycle N+1. With wr_ready tied high, there is one word per cycle and no gaps between groups.
- Address generation:
  - Filter counter f and pixel counter p; wr_addr = p*nf + f, kept as a running base register (no multiplier).
  - f increments per handshake. When f reaches nf-1, the next handshake wraps f to 0 and increments p.
  - Address arithmetic is ADDR_W bits; wrap beyond 2^ADDR_W is not checked.
- Reset mid-layer: everything clears immediately and in-flight data is discarded. No done pulse is produced.

Optional Feature:
OFM_RELU_EN
- Defined: each word is clamped at pop time. If the MSB of the signed word is set, wr_data = 0; otherwise the word passes unchanged. overflow and addressing are unaffected.
- Undefined: wr_data is the raw two's-complement pe_psum slice.

Test Plan:
- Basic layer:
  - Stimulus: start with nf=8, np=2, wr_ready=1. Four pe_finish=1111 pulses, each held 3 cycles, with psum words 0x10+k.
  - Response: 16 writes at addr 0..15 in capture order; done pulses once when the 16th word is accepted; overflow stays 0.
- Backpressure:
  - Stimulus: nf=4, np=1, wr_ready low for 5 cycles after the first wr_valid.
  - Response: wr_addr=0 and wr_data held for 5 cycles; then addr 0..3 are written.
- FIFO full:
  - Stimulus: FIFO_DEPTH=8, wr_ready=0, 9 captures.
  - Response: 8 groups held, overflow=1. After wr_ready=1, exactly 32 words are written.
- Boundary with simultaneous pop:
  - Stimulus: FIFO full; a capture coincides with the 4th handshake of the head group.
  - Response: capture accepted, overflow stays 0.
- Config edges:
  - Stimulus: start with nf=6 (treated as 4), np=3.
  - Response: 12 writes, addresses 0..11.
  - Stimulus: start with np=0.
  - Response: done one cycle after start, no writes.
- Reset and feature build:
  - Stimulus: assert reset_n low mid-layer after 5 words.
  - Response: all outputs 0, no done; the next start restarts at addr 0.
  - Stimulus: OFM_RELU_EN build, psum = 0xFFFFFFF0.
  - Response: wr_data = 0.

Source files
------------

// File: rtl/conv1x1_ofm_writer.sv
// Captures 4-filter PE results per pixel, buffers them in a group FIFO and serialises them into OFM word writes.
// Optional build macro OFM_RELU_EN clamps negative words to zero on the write port.
module conv1x1_ofm_writer #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_PE     = 4,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     start,
   input  logic [10:0]              cfg_num_filter,
   input  logic [15:0]              cfg_num_pixel,
   input  logic [3:0]               pe_finish,
   input  logic [NUM_PE*DATA_W-1:0] pe_psum,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t state_q, state_d;

   logic [10:0]              nf_q;
   logic [15:0]              np_q;
   logic                     all_hi_q;
   logic [10:0]              wf_q;
   logic [15:0]              wp_q;
   logic [ADDR_W-1:0]        base_q;
   logic [10:0]              cf_q;
   logic [15:0]              cp_q;
   logic [1:0]               beat_q;
   logic [PTR_W-1:0]         rd_ptr_q, wr_ptr_q;
   logic [CNT_W-1:0]         cnt_q;
   logic                     ovf_q;
   logic [NUM_PE*DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic                     all_hi, fire, run, fifo_full, valid, hs, pop;
   logic                     limit, push, drop, last_word;
   logic [10:0]              nf_in;
   logic [NUM_PE*DATA_W-1:0] head;
   logic [DATA_W-1:0]        word;

   assign nf_in     = cfg_num_filter & ~11'd3;
   assign all_hi    = &pe_finish;
   assign fire      = all_hi && !all_hi_q;
   assign run       = (state_q == S_RUN);
   assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
   assign valid     = run && (cnt_q != '0);
   assign hs        = valid && wr_ready;
   assign pop       = hs && (beat_q == 2'(NUM_PE - 1));
   // Group budget is reached once the capture pixel counter has covered every pixel.
   assign limit     = (cp_q == np_q);
   assign push      = run && fire && !limit && (!fifo_full || pop);
   assign drop      = run && fire && !push;
   assign last_word = hs && (wf_q == nf_q - 11'd1) && (wp_q == np_q - 16'd1);

   assign head = mem_q[rd_ptr_q];
   assign word = head[DATA_W*beat_q +: DATA_W];

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (nf_in == '0 || cfg_num_pixel == '0) state_d = S_DONE;
               else                                    state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (last_word) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         nf_q     <= '0;
         np_q     <= '0;
         all_hi_q <= 1'b0;
         wf_q     <= '0;
         wp_q     <= '0;
         base_q   <= '0;
         cf_q     <= '0;
         cp_q     <= '0;
         beat_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         all_hi_q <= all_hi;
         if (state_q == S_IDLE && start) begin
            nf_q     <= nf_in;
            np_q     <= cfg_num_pixel;
            wf_q     <= '0;
            wp_q     <= '0;
            base_q   <= '0;
            cf_q     <= '0;
            cp_q     <= '0;
            beat_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
         end else if (run) begin
            if (hs) begin
               beat_q <= beat_q + 2'd1;
               if (wf_q == nf_q - 11'd1) begin
                  wf_q   <= '0;
                  wp_q   <= wp_q + 16'd1;
                  base_q <= base_q + ADDR_W'(nf_q);
               end else begin
                  wf_q <= wf_q + 11'd1;
               end
            end
            if (push) begin
               wr_ptr_q <= wr_ptr_q + 1'b1;
               if (cf_q == nf_q - 11'd4) begin
                  cf_q <= '0;
                  cp_q <= cp_q + 16'd1;
               end else begin
                  cf_q <= cf_q + 11'd4;
               end
            end
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop) ovf_q    <= 1'b1;
            cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= pe_psum;
   end

   assign wr_valid = valid;
   assign wr_addr  = valid ? (base_q + ADDR_W'(wf_q)) : '0;
`ifdef OFM_RELU_EN
   assign wr_data  = (valid && !word[DATA_W-1]) ? word : '0;
`else
   assign wr_data  = valid ? word : '0;
`endif
   assign busy     = run;
   assign done     = (state_q == S_DONE);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_conv1x1_ofm_writer.sv
// Directed bench for conv1x1_ofm_writer: layer drain, backpressure, FIFO full/drop, config edges, reset, ReLU.
module tb_conv1x1_ofm_writer;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         start = 1'b0;
   logic [10:0]  cfg_num_filter = '0;
   logic [15:0]  cfg_num_pixel = '0;
   logic [3:0]   pe_finish = '0;
   logic [127:0] pe_psum = '0;
   logic         wr_ready = 1'b0;
   logic         wr_valid;
   logic [31:0]  wr_addr;
   logic [31:0]  wr_data;
   logic         busy;
   logic         done;
   logic         overflow;

   int checks = 0;
   int errors = 0;
   int n_wr = 0;
   int done_cnt = 0;
   logic [31:0] log_addr [256];
   logic [31:0] log_data [256];

   conv1x1_ofm_writer #(
      .DATA_W(32), .NUM_PE(4), .FIFO_DEPTH(8), .ADDR_W(32)
   ) dut (
      .clk(clk), .reset_n(reset_n), .start(start),
      .cfg_num_filter(cfg_num_filter), .cfg_num_pixel(cfg_num_pixel),
      .pe_finish(pe_finish), .pe_psum(pe_psum),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after posedge, so mid-cycle values equal what the next posedge sees.
   always @(negedge clk) begin
      if (wr_valid && wr_ready) begin
         if (n_wr < 256) begin
            log_addr[n_wr] <= wr_addr;
            log_data[n_wr] <= wr_data;
         end
         n_wr <= n_wr + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [127:0] grp(input int b);
      logic [127:0] r;
      for (int k = 0; k < 4; k++) r[32*k +: 32] = 32'(b + k);
      return r;
   endfunction

   task automatic do_start(input int nf, input int np);
      cfg_num_filter = 11'(nf);
      cfg_num_pixel  = 16'(np);
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic capture(input logic [127:0] psum, input int hold);
      pe_psum   = psum;
      pe_finish = 4'hF;
      step(hold);
      pe_finish = 4'h0;
      step(1);
   endtask

   task automatic wait_done(input int budget, input int d0);
      int t = 0;
      while (done_cnt == d0 && t < budget) begin
         step(1);
         t++;
      end
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL done_timeout: done count %0d required %0d", done_cnt, d0 + 1);
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({wr_valid, busy, done, overflow} !== 4'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_in: valid/busy/done/ovf %b addr %h data %h required all 0",
                  {wr_valid, busy, done, overflow}, wr_addr, wr_data);
      end
      reset_n = 1'b1;
      step(2);
      checks++;
      if ({wr_valid, busy, done, overflow} !== 4'b0 || wr_addr !== 32'h0) begin
         errors++;
         $display("FAIL reset_out: valid/busy/done/ovf %b addr %h required 0",
                  {wr_valid, busy, done, overflow}, wr_addr);
      end
   endtask

   task automatic test_basic();
      int b = n_wr;
      int d0 = done_cnt;
      wr_ready = 1'b1;
      do_start(8, 2);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_busy: got %b required 1", busy);
      end
      for (int g = 0; g < 4; g++) capture(grp(16 + 4*g), 3);
      wait_done(60, d0);
      step(3);
      checks++;
      if (n_wr - b !== 16) begin
         errors++;
         $display("FAIL basic_count: got %0d required 16", n_wr - b);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (log_addr[b+i] !== 32'(i) || log_data[b+i] !== 32'(16 + i)) begin
            errors++;
            $display("FAIL basic_word%0d: addr %h data %h required addr %h data %h",
                     i, log_addr[b+i], log_data[b+i], i, 16 + i);
         end
      end
      checks++;
      if (done_cnt - d0 !== 1 || overflow !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_end: done pulses %0d ovf %b busy %b required 1 0 0",
                  done_cnt - d0, overflow, busy);
      end
   endtask

   task automatic test_backpressure();
      int b = n_wr;
      int d0 = done_cnt;
      int t = 0;
      wr_ready = 1'b0;
      do_start(4, 1);
      capture(grp(32'hA0), 1);
      while (!wr_valid && t < 10) begin
         step(1);
         t++;
      end
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (wr_valid !== 1'b1 || wr_addr !== 32'h0 || wr_data !== 32'hA0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid %b addr %h data %h required 1 0 a0",
                     c, wr_valid, wr_addr, wr_data);
         end
         step(1);
      end
      wr_ready = 1'b1;
      wait_done(20, d0);
      checks++;
      if (n_wr - b !== 4) begin
         errors++;
         $display("FAIL bp_count: got %0d required 4", n_wr - b);
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (log_addr[b+i] !== 32'(i) || log_data[b+i] !== 32'(32'hA0 + i)) begin
            errors++;
            $display("FAIL bp_word%0d: addr %h data %h required %h %h",
                     i, log_addr[b+i], log_data[b+i], i, 32'hA0 + i);
         end
      end
   endtask

   task automatic test_fifo_full();
      int b = n_wr;
      int d0 = done_cnt;
      wr_ready = 1'b0;
      do_start(4, 9);
      for (int g = 0; g < 9; g++) capture(grp(32'h100 + 4*g), 1);
      checks++;
      if (overflow !== 1'b1 || wr_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_ovf: ovf %b valid %b required 1 1", overflow, wr_valid);
      end
      wr_ready = 1'b1;
      step(40);
      checks++;
      if (n_wr - b !== 32 || busy !== 1'b1) begin
         errors++;
         $display("FAIL full_drain: words %0d busy %b required 32 1", n_wr - b, busy);
      end
      for (int i = 0; i < 32; i += 5) begin
         checks++;
         if (log_addr[b+i] !== 32'(i) || log_data[b+i] !== 32'(32'h100 + i)) begin
            errors++;
            $display("FAIL full_word%0d: addr %h data %h required %h %h",
                     i, log_addr[b+i], log_data[b+i], i, 32'h100 + i);
         end
      end
      capture(grp(32'h200), 1);
      wait_done(20, d0);
      checks++;
      if (log_addr[b+35] !== 32'd35 || log_data[b+35] !== 32'h203 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL full_tail: addr %h data %h ovf %b required 23 203 1",
                  log_addr[b+35], log_data[b+35], overflow);
      end
   endtask

   task automatic test_simul_pop();
      int b = n_wr;
      int d0 = done_cnt;
      wr_ready = 1'b0;
      do_start(4, 10);
      for (int g = 0; g < 8; g++) capture(grp(32'h300 + 4*g), 1);
      wr_ready = 1'b1;
      step(3);
      pe_psum   = grp(32'h380);
      pe_finish = 4'hF;
      step(1);
      pe_finish = 4'h0;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL pop_ovf: got %b required 0", overflow);
      end
      step(40);
      checks++;
      if (n_wr - b !== 36) begin
         errors++;
         $display("FAIL pop_count: got %0d required 36", n_wr - b);
      end
      for (int i = 32; i < 36; i++) begin
         checks++;
         if (log_addr[b+i] !== 32'(i) || log_data[b+i] !== 32'(32'h380 + i - 32)) begin
            errors++;
            $display("FAIL pop_word%0d: addr %h data %h required %h %h",
                     i, log_addr[b+i], log_data[b+i], i, 32'h380 + i - 32);
         end
      end
      capture(grp(32'h400), 1);
      wait_done(20, d0);
      checks++;
      if (overflow !== 1'b0 || n_wr - b !== 40) begin
         errors++;
         $display("FAIL pop_end: ovf %b words %0d required 0 40", overflow, n_wr - b);
      end
   endtask

   task automatic test_cfg_edges();
      int b = n_wr;
      int d0 = done_cnt;
      wr_ready = 1'b1;
      do_start(6, 3);
      for (int g = 0; g < 3; g++) capture(grp(32'h500 + 4*g), 1);
      wait_done(30, d0);
      step(2);
      checks++;
      if (n_wr - b !== 12) begin
         errors++;
         $display("FAIL nf6_count: got %0d required 12", n_wr - b);
      end
      for (int i = 0; i < 12; i++) begin
         checks++;
         if (log_addr[b+i] !== 32'(i) || log_data[b+i] !== 32'(32'h500 + i)) begin
            errors++;
            $display("FAIL nf6_word%0d: addr %h data %h required %h %h",
                     i, log_addr[b+i], log_data[b+i], i, 32'h500 + i);
         end
      end
      b = n_wr;
      do_start(4, 0);
      checks++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL np0_done: done %b busy %b required 1 0", done, busy);
      end
      step(1);
      checks++;
      if (done !== 1'b0 || n_wr != b) begin
         errors++;
         $display("FAIL np0_after: done %b writes %0d required 0 0", done, n_wr - b);
      end
   endtask

   task automatic test_reset_mid();
      int b = n_wr;
      int d0;
      int t = 0;
      wr_ready = 1'b1;
      do_start(4, 4);
      capture(grp(32'h600), 1);
      capture(grp(32'h604), 1);
      while (n_wr - b < 5 && t < 20) begin
         step(1);
         t++;
      end
      d0 = done_cnt;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({wr_valid, busy, done, overflow} !== 4'b0 || wr_addr !== 32'h0 || wr_data !== 32'h0) begin
         errors++;
         $display("FAIL rst_mid: valid/busy/done/ovf %b addr %h data %h required all 0",
                  {wr_valid, busy, done, overflow}, wr_addr, wr_data);
      end
      step(2);
      reset_n = 1'b1;
      step(3);
      checks++;
      if (done_cnt !== d0) begin
         errors++;
         $display("FAIL rst_nodone: done pulses %0d required 0", done_cnt - d0);
      end
      b = n_wr;
      d0 = done_cnt;
      do_start(4, 1);
      capture(grp(32'h700), 1);
      wait_done(20, d0);
      checks++;
      if (n_wr - b !== 4 || log_addr[b] !== 32'h0 || log_data[b] !== 32'h700) begin
         errors++;
         $display("FAIL rst_restart: words %0d addr %h data %h required 4 0 700",
                  n_wr - b, log_addr[b], log_data[b]);
      end
   endtask

   task automatic test_relu();
      int b = n_wr;
      int d0 = done_cnt;
      logic [31:0] exp_w [4];
      logic [127:0] p;
      p = {32'd5, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF0};
`ifdef OFM_RELU_EN
      exp_w = '{32'h0, 32'h7FFF_FFFF, 32'h0, 32'd5};
`else
      exp_w = '{32'hFFFF_FFF0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5};
`endif
      wr_ready = 1'b1;
      do_start(4, 1);
      capture(p, 1);
      wait_done(20, d0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (log_data[b+i] !== exp_w[i] || log_addr[b+i] !== 32'(i)) begin
            errors++;
            $display("FAIL relu_word%0d: addr %h data %h required %h %h",
                     i, log_addr[b+i], log_data[b+i], i, exp_w[i]);
         end
      end
   endtask

   initial begin
      step(2);
      test_reset();
      test_basic();
      test_backpressure();
      test_fifo_full();
      test_simul_pop();
      test_cfg_edges();
      test_reset_mid();
      test_relu();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
